uart_rx: RTL and testbench

- Standalone UART receiver core.
- Samples the asynchronous serial line `rx`, deserialises LSB-first frames and presents each byte on `data_o` with a one-cycle `valid` strobe.
- Frame format is runtime-configurable and matches the transmitter's options: data length, stop bit count and parity.
- Sits between the USB-RS232/PMOD pin and board-level logic (SSD display, loopback checks).

---
 rtl/uart_rx.sv | 149 ++++++++++++++
 tb/tb_uart_rx.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronised line, runtime frame format (7/8 data bits,
// optional parity, 1/2 stop bits), one-cycle valid strobe per received byte.
//
// state  | meaning
// IDLE   | line idle, waiting for a falling edge on rx_s
// START  | timing to start-bit mid-point, rejecting glitches
// DATA   | sampling data bits LSB-first
// PARITY | sampling the parity bit
// STOP1  | sampling the first stop bit
// STOP2  | sampling the second stop bit
// DONE   | publishing data and error flags for one cycle
// BREAK  | line held low after a frame, waiting for it to return high
module uart_rx #(
  parameter int BAUD_DIV = 868,
  parameter int HALF_DIV = BAUD_DIV / 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       data_size,
  input  logic       stop_bit_size,
  input  logic       parity_en,
  input  logic [1:0] parity_mode,
  output logic [7:0] data_o,
  output logic       valid,
  output logic       ready,
  output logic       parity_err,
  output logic       frame_err
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] FULL_CNT = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_CNT = CW'(HALF_DIV - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP1  = 3'd4;
  localparam logic [2:0] STOP2  = 3'd5;
  localparam logic [2:0] DONE   = 3'd6;
  localparam logic [2:0] BREAK  = 3'd7;

  logic [2:0]    state;
  logic          rx_m, rx_s, rx_d;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          cfg_size, cfg_stop2, cfg_par_en;
  logic [1:0]    cfg_pmode;
  logic          perr, ferr;

  logic          fall;
  logic          sampling;
  logic          sample;
  logic          dpar;
  logic          par_exp;
  logic [2:0]    last_idx;

  always_comb begin
    fall     = rx_d & ~rx_s;
    sampling = (state == START) || (state == DATA) || (state == PARITY) ||
               (state == STOP1) || (state == STOP2);
    sample   = sampling && (cnt == ((state == START) ? HALF_CNT : FULL_CNT));
    last_idx = cfg_size ? 3'd6 : 3'd7;
    // In 7-bit mode the data ends up in shreg[7:1]; shreg[0] is stale.
    dpar     = cfg_size ? ^shreg[7:1] : ^shreg;
    case (cfg_pmode)
      2'b00:   par_exp = dpar;
      2'b01:   par_exp = ~dpar;
      2'b10:   par_exp = 1'b1;
      default: par_exp = 1'b0;
    endcase
    ready    = (state == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_m       <= 1'b1;
      rx_s       <= 1'b1;
      rx_d       <= 1'b1;
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '1;
      cfg_size   <= 1'b0;
      cfg_stop2  <= 1'b0;
      cfg_par_en <= 1'b0;
      cfg_pmode  <= 2'b00;
      perr       <= 1'b0;
      ferr       <= 1'b0;
      data_o     <= 8'h00;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_m  <= rx;
      rx_s  <= rx_m;
      rx_d  <= rx_s;
      valid <= 1'b0;
      cnt   <= (sampling && !sample) ? cnt + 1'b1 : '0;
      case (state)
        IDLE: if (fall) begin
          state      <= START;
          cfg_size   <= data_size;
          cfg_stop2  <= stop_bit_size;
          cfg_par_en <= parity_en;
          cfg_pmode  <= parity_mode;
          perr       <= 1'b0;
          ferr       <= 1'b0;
        end
        START: if (sample) begin
          if (rx_s) state <= IDLE;
          else begin
            state   <= DATA;
            bit_idx <= '0;
          end
        end
        DATA: if (sample) begin
          shreg <= {rx_s, shreg[7:1]};
          if (bit_idx == last_idx) state <= cfg_par_en ? PARITY : STOP1;
          else bit_idx <= bit_idx + 1'b1;
        end
        PARITY: if (sample) begin
          if (rx_s != par_exp) perr <= 1'b1;
          state <= STOP1;
        end
        STOP1: if (sample) begin
          if (!rx_s) ferr <= 1'b1;
          state <= cfg_stop2 ? STOP2 : DONE;
        end
        STOP2: if (sample) begin
          if (!rx_s) ferr <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          data_o     <= cfg_size ? {1'b0, shreg[7:1]} : shreg;
          parity_err <= perr;
          frame_err  <= ferr;
          valid      <= 1'b1;
          state      <= rx_s ? IDLE : BREAK;
        end
        BREAK: if (rx_s) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at BAUD_DIV=16: frame formats, parity, glitch,
// break, back-to-back frames and reset mid-frame.
module tb_uart_rx;

  localparam int BAUD = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       data_size;
  logic       stop_bit_size;
  logic       parity_en;
  logic [1:0] parity_mode;
  logic [7:0] data_o;
  logic       valid;
  logic       ready;
  logic       parity_err;
  logic       frame_err;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int vcount = 0;
  logic [7:0] vdata[$];
  int vtime[$];
  logic ready_or;
  int base;

  uart_rx #(.BAUD_DIV(BAUD), .HALF_DIV(BAUD / 2)) dut (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .data_size(data_size),
    .stop_bit_size(stop_bit_size),
    .parity_en(parity_en),
    .parity_mode(parity_mode),
    .data_o(data_o),
    .valid(valid),
    .ready(ready),
    .parity_err(parity_err),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (valid) begin
      vcount++;
      vdata.push_back(data_o);
      vtime.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic v, input logic samp);
    rx = v;
    for (int i = 0; i < BAUD; i++) begin
      @(negedge clk);
      if (samp && i == BAUD / 2) ready_or = ready_or | ready;
    end
  endtask

  task automatic send(input logic [7:0] d, input int nbits, input logic has_par,
                      input logic par, input int nstop, input logic stopval);
    ready_or = 1'b0;
    drive_bit(1'b0, 1'b1);
    for (int i = 0; i < nbits; i++) drive_bit(d[i], 1'b1);
    if (has_par) drive_bit(par, 1'b1);
    for (int i = 0; i < nstop; i++) drive_bit(stopval, 1'b0);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    rx = 1'b1;
    data_size = 1'b0;
    stop_bit_size = 1'b0;
    parity_en = 1'b0;
    parity_mode = 2'b00;
    repeat (4) @(negedge clk);
    check("rst_data", data_o, 8'h00);
    check("rst_valid", valid, 1'b0);
    check("rst_ready", ready, 1'b1);
    check("rst_perr", parity_err, 1'b0);
    check("rst_ferr", frame_err, 1'b0);
    rst = 1'b1;
    idle(4);

    // 8N1 0xA5
    base = vcount;
    send(8'hA5, 8, 1'b0, 1'b0, 1, 1'b1);
    idle(4);
    check("a5_count", vcount - base, 1);
    check("a5_data", data_o, 8'hA5);
    check("a5_perr", parity_err, 1'b0);
    check("a5_ferr", frame_err, 1'b0);
    check("a5_ready_in_frame", ready_or, 1'b0);
    check("a5_ready_after", ready, 1'b1);

    // 7-bit, odd parity, 2 stop bits
    data_size = 1'b1;
    stop_bit_size = 1'b1;
    parity_en = 1'b1;
    parity_mode = 2'b01;
    base = vcount;
    send(8'h53, 7, 1'b1, 1'b1, 2, 1'b1);
    idle(4);
    check("p53_count", vcount - base, 1);
    check("p53_data", data_o, 8'h53);
    check("p53_perr", parity_err, 1'b0);
    send(8'h53, 7, 1'b1, 1'b0, 2, 1'b1);
    idle(4);
    check("p53bad_count", vcount - base, 2);
    check("p53bad_data", data_o, 8'h53);
    check("p53bad_perr", parity_err, 1'b1);
    check("p53bad_ferr", frame_err, 1'b0);

    // glitch: 4 cycles low
    base = vcount;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    check("glitch_ready_low", ready, 1'b0);
    idle(3 * BAUD);
    check("glitch_count", vcount - base, 0);
    check("glitch_data", data_o, 8'h53);
    check("glitch_ready", ready, 1'b1);

    // framing error followed by break
    data_size = 1'b0;
    stop_bit_size = 1'b0;
    parity_en = 1'b0;
    parity_mode = 2'b00;
    base = vcount;
    send(8'h00, 8, 1'b0, 1'b0, 1, 1'b0);
    rx = 1'b0;
    repeat (40 * BAUD) @(negedge clk);
    check("brk_count", vcount - base, 1);
    check("brk_data", data_o, 8'h00);
    check("brk_ferr", frame_err, 1'b1);
    check("brk_perr", parity_err, 1'b0);
    check("brk_ready_low", ready, 1'b0);
    idle(4);
    check("brk_ready_high", ready, 1'b1);
    idle(2 * BAUD);
    check("brk_count_after", vcount - base, 1);

    // back-to-back 8N1
    base = vcount;
    send(8'h12, 8, 1'b0, 1'b0, 1, 1'b1);
    send(8'h34, 8, 1'b0, 1'b0, 1, 1'b1);
    idle(4);
    check("b2b_count", vcount - base, 2);
    if (vcount - base == 2) begin
      check("b2b_first", vdata[base], 8'h12);
      check("b2b_second", vdata[base + 1], 8'h34);
      check("b2b_gap", vtime[base + 1] - vtime[base], BAUD * 10);
    end
    check("b2b_ferr", frame_err, 1'b0);

    // reset during data bit 3 of 0xFF
    base = vcount;
    ready_or = 1'b0;
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b1, 1'b0);
    repeat (BAUD / 2) @(negedge clk);
    check("mid_ready_busy", ready, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_data", data_o, 8'h00);
    check("mid_rst_ready", ready, 1'b1);
    check("mid_rst_valid", valid, 1'b0);
    rst = 1'b1;
    idle(6 * BAUD);
    check("mid_rst_count", vcount - base, 0);
    send(8'h3C, 8, 1'b0, 1'b0, 1, 1'b1);
    idle(4);
    check("post_rst_count", vcount - base, 1);
    check("post_rst_data", data_o, 8'h3C);
    check("post_rst_ferr", frame_err, 1'b0);
    check("post_rst_perr", parity_err, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
